// File: rtl/viterbi_pkg.sv
// Shared types and constants for the K=3, rate-1/2 Viterbi decoder.
//   vit_ctrl_state_t : frame sequencer state encoding
//   VIT_K            : constraint length
//   VIT_NUM_STATES   : trellis states (2**(K-1))
//   VIT_FRAME_LEN    : default symbols per frame, tail included
package viterbi_pkg;

    localparam int unsigned VIT_K          = 3;
    localparam int unsigned VIT_NUM_STATES = 2 ** (VIT_K - 1);
    localparam int unsigned VIT_FRAME_LEN  = 15;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACS     = 3'd1,
        TB_WAIT = 3'd2,
        TRACE   = 3'd3,
        DONE    = 3'd4
    } vit_ctrl_state_t;

endpackage

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for the Viterbi ACS / survivor-memory / traceback datapath.
// Accepts one FRAME_LEN-symbol frame per start pulse, strobes one ACS step and
// one survivor write per accepted symbol, then sweeps the survivor memory
// backwards for traceback and pulses frame_done.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : frame start, honoured in IDLE only
//   sym_valid/ready   : symbol handshake (ready only while collecting symbols)
//   pm_msb            : any path metric has reached its MSB
//   tb_ready          : traceback unit can take a read this cycle
//   acs_en/acs_init/pm_norm/tail_sym : per-symbol ACS controls
//   surv_we/surv_addr : survivor write strobe and address (symbol index)
//   tb_rd_en/tb_addr/tb_last : traceback read strobe, address, final read
//   busy, frame_done  : status
module viterbi_frame_ctrl
    import viterbi_pkg::*;
#(
    parameter  int unsigned FRAME_LEN = VIT_FRAME_LEN,
    parameter  int unsigned K         = VIT_K,
    localparam int unsigned AW        = $clog2(FRAME_LEN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          sym_valid,
    output logic          sym_ready,
    input  logic          pm_msb,
    input  logic          tb_ready,
    output logic          acs_en,
    output logic          acs_init,
    output logic          pm_norm,
    output logic          tail_sym,
    output logic          surv_we,
    output logic [AW-1:0] surv_addr,
    output logic          tb_rd_en,
    output logic [AW-1:0] tb_addr,
    output logic          tb_last,
    output logic          busy,
    output logic          frame_done
);

    localparam logic [AW-1:0] LAST_IDX   = AW'(FRAME_LEN - 1);
    localparam logic [AW-1:0] TAIL_START = AW'(FRAME_LEN - (K - 1));

    vit_ctrl_state_t state_q, state_d;
    logic [AW-1:0]   sym_cnt_q, sym_cnt_d;
    logic [AW-1:0]   tb_cnt_q, tb_cnt_d;
    logic            norm_pend_q, norm_pend_d;
    logic            accept;

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sym_cnt_q   <= '0;
            tb_cnt_q    <= '0;
            norm_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sym_cnt_q   <= sym_cnt_d;
            tb_cnt_q    <= tb_cnt_d;
            norm_pend_q <= norm_pend_d;
        end
    end

    // Next-state and output decode; ACS strobes follow the handshake in-cycle
    always_comb begin
        state_d     = state_q;
        sym_cnt_d   = sym_cnt_q;
        tb_cnt_d    = tb_cnt_q;
        norm_pend_d = norm_pend_q;
        accept      = 1'b0;
        sym_ready   = 1'b0;
        acs_en      = 1'b0;
        acs_init    = 1'b0;
        pm_norm     = 1'b0;
        tail_sym    = 1'b0;
        surv_we     = 1'b0;
        surv_addr   = '0;
        tb_rd_en    = 1'b0;
        tb_addr     = '0;
        tb_last     = 1'b0;
        frame_done  = 1'b0;
        busy        = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = ACS;
                    sym_cnt_d   = '0;
                    norm_pend_d = 1'b0;
                end
            end

            ACS: begin
                sym_ready = 1'b1;
                accept    = sym_valid;
                acs_en    = accept;
                surv_we   = accept;
                surv_addr = sym_cnt_q;
                acs_init  = accept && (sym_cnt_q == '0);
                tail_sym  = accept && (sym_cnt_q >= TAIL_START);
                // The init step loads fresh metrics, so a pending norm waits for the next symbol
                pm_norm   = accept && norm_pend_q && !acs_init;

                // Clear wins: metrics being normalised now already absorb the overflow
                if (pm_norm) begin
                    norm_pend_d = 1'b0;
                end else if (pm_msb) begin
                    norm_pend_d = 1'b1;
                end

                if (accept) begin
                    sym_cnt_d = sym_cnt_q + AW'(1);
                    if (sym_cnt_q == LAST_IDX) begin
                        state_d = TB_WAIT;
                    end
                end
            end

            // One bubble so the final survivor write lands before traceback reads it
            TB_WAIT: begin
                state_d  = TRACE;
                tb_cnt_d = LAST_IDX;
            end

            TRACE: begin
                tb_rd_en = tb_ready;
                tb_addr  = tb_cnt_q;
                if (tb_ready) begin
                    if (tb_cnt_q == '0) begin
                        tb_last = 1'b1;
                        state_d = DONE;
                    end else begin
                        tb_cnt_d = tb_cnt_q - AW'(1);
                    end
                end
            end

            DONE: begin
                frame_done = 1'b1;
                state_d    = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
